regfile_dump_reader: RTL and testbench

Read-side client of the 8 x 10-bit register file. On a start command it walks a register address range through one combinational read port and streams each word out on a valid/ready interface. The output goes to the debug/trace path. It owns one read port (raddr/rdata) and never writes the register file.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_dump_reader.sv | 114 +++++++++++
 tb/tb_regfile_dump_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//
// Shared definitions for the 8 x 10-bit register file and its clients.
//   RF_DATA_W    register word width
//   RF_ADDR_W    register address width
//   RF_NUM_REGS  number of registers (2**RF_ADDR_W)
//   DUMP_*       state encoding of the dump reader FSM
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int RF_DATA_W   = 10;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_NUM_REGS = 8;

    // Dump reader FSM encoding. Plain constants rather than an enum so the
    // encoding is visible to tools and scripts that expect fixed codes.
    localparam logic [1:0] DUMP_IDLE  = 2'd0;
    localparam logic [1:0] DUMP_FETCH = 2'd1;
    localparam logic [1:0] DUMP_SEND  = 2'd2;

endpackage : regfile_pkg

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Read-only client of the register file. On start it walks the address range
// first_addr..last_addr (inclusive, wrapping modulo 2**ADDR_W) through one
// combinational read port and streams every word out on a valid/ready
// interface to the debug/trace path. One beat every two cycles at best.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle dump request, honoured only while idle
//   first_addr  first register to read, sampled with start
//   last_addr   last register to read (inclusive), sampled with start
//   busy        high whenever the reader is not idle
//   done        one-cycle pulse after the final beat is accepted
//   raddr       read address to the register file
//   rdata       combinational read data from the register file
//   out_valid   out_data/out_addr/out_last hold a beat
//   out_ready   downstream accepts the beat when out_valid is also high
//   out_data    captured register value
//   out_addr    address the value was read from
//   out_last    final beat of the dump
// -----------------------------------------------------------------------------
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] end_addr;
    logic              accept;

    assign accept = out_valid && out_ready;
    assign busy   = (state != DUMP_IDLE);

    // raddr doubles as the walk cursor: it is loaded when entering FETCH and
    // simply holds its value everywhere else, so the read port only ever sees
    // the address being fetched or the one last fetched.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values, whatever the statement order.
        if (rst) begin
            state     <= DUMP_IDLE;
            end_addr  <= '0;
            raddr     <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a
            // single-cycle pulse, set below on the final accepted beat.
            done <= 1'b0;

            case (state)
                DUMP_IDLE: begin
                    if (start) begin
                        raddr    <= first_addr;
                        end_addr <= last_addr;
                        state    <= DUMP_FETCH;
                    end
                end

                DUMP_FETCH: begin
                    // Snapshot the word now; later register-file writes do
                    // not disturb the beat while it waits in SEND.
                    out_data  <= rdata;
                    out_addr  <= raddr;
                    out_last  <= (raddr == end_addr);
                    out_valid <= 1'b1;
                    state     <= DUMP_SEND;
                end

                DUMP_SEND: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DUMP_IDLE;
                        end else begin
                            // Natural wrap from 2**ADDR_W-1 to 0.
                            raddr <= raddr + ADDR_W'(1);
                            state <= DUMP_FETCH;
                        end
                    end
                end

                default: begin
                    state <= DUMP_IDLE;
                end
            endcase
        end
    end

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Directed bench for regfile_dump_reader. A small register-file model drives
// rdata combinationally from raddr. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the rising active edge.
// The "start edge" is the last rising edge before start is driven; start is
// sampled on the following rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;
    import regfile_pkg::*;

    localparam int DW = RF_DATA_W;
    localparam int AW = RF_ADDR_W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;

    logic [DW-1:0] rf [RF_NUM_REGS];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;
    int done_pulses = 0;

    assign rdata = rf[raddr];

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .raddr      (raddr),
        .rdata      (rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_pulses <= done_pulses + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive start for one sampling edge; returns at the next falling edge.
    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        start      = 1'b1;
        first_addr = f;
        last_addr  = l;
        start_cyc  = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Wait (bounded) for a beat, check it, optionally stall it for `stall`
    // cycles while checking that it holds. Returns at a falling edge with
    // out_ready high so the beat is accepted on the next rising edge.
    task automatic expect_beat(input string tag, input int a, input int d,
                               input int last, input int stall);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, "_addr"}, 32'(out_addr), 32'(a));
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_last"}, 32'(out_last), 32'(last));
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_addr"},  32'(out_addr),  32'(a));
                check({tag, "_hold_data"},  32'(out_data),  32'(d));
            end
            out_ready = 1'b1;
        end
    endtask

    // Expect done on the falling edge after the final handshake.
    task automatic expect_done(input string tag, input int latency);
        @(negedge clk);
        check({tag, "_done"},    32'(done),            32'd1);
        check({tag, "_busy"},    32'(busy),            32'd0);
        check({tag, "_latency"}, 32'(cyc - start_cyc), 32'(latency));
        @(negedge clk);
        check({tag, "_done_end"}, 32'(done),      32'd0);
        check({tag, "_no_more"},  32'(out_valid), 32'd0);
    endtask

    initial begin
        int pulses0;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < RF_NUM_REGS; i++) rf[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_raddr",     32'(raddr),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_addr",  32'(out_addr),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        rst = 1'b0;
        rf[0] = 10'd55;
        rf[1] = 10'd200;
        rf[2] = 10'd7;
        rf[3] = 10'd1023;
        @(negedge clk);

        // 1. Range dump 0..3, out_ready high: done 9 cycles after start edge
        pulses0 = done_pulses;
        do_start(3'd0, 3'd3);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_first_valid", 32'(out_valid), 32'd1);
        check("t1_first_lat",   32'(cyc - start_cyc), 32'd2);
        check("t1_b0_addr",     32'(out_addr), 32'd0);
        check("t1_b0_data",     32'(out_data), 32'd55);
        check("t1_b0_last",     32'(out_last), 32'd0);
        expect_beat("t1_b1", 1, 200, 0, 0);
        expect_beat("t1_b2", 2, 7, 0, 0);
        expect_beat("t1_b3", 3, 1023, 1, 0);
        expect_done("t1", 9);
        check("t1_pulses", 32'(done_pulses - pulses0), 32'd1);

        // 2. Backpressure on beat 1 for 3 cycles
        do_start(3'd0, 3'd3);
        expect_beat("t2_b0", 0, 55, 0, 0);
        expect_beat("t2_b1", 1, 200, 0, 3);
        expect_beat("t2_b2", 2, 7, 0, 0);
        expect_beat("t2_b3", 3, 1023, 1, 0);
        expect_done("t2", 12);

        // 3. Wrap-around 6..1
        do_start(3'd6, 3'd1);
        expect_beat("t3_b0", 6, 0, 0, 0);
        expect_beat("t3_b1", 7, 0, 0, 0);
        expect_beat("t3_b2", 0, 55, 0, 0);
        expect_beat("t3_b3", 1, 200, 1, 0);
        expect_done("t3", 9);

        // 4. Single beat with a register write while the beat is stalled
        do_start(3'd2, 3'd2);
        expect_beat("t4_b0", 2, 7, 1, 0);
        out_ready = 1'b0;
        rf[2] = 10'd99;
        repeat (2) @(negedge clk);
        check("t4_snapshot",  32'(out_data),  32'd7);
        check("t4_raddr",     32'(raddr),     32'd2);
        check("t4_still_val", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        expect_done("t4", 5);

        // 5. start while busy is ignored
        do_start(3'd0, 3'd3);
        expect_beat("t5_b0", 0, 55, 0, 0);
        start      = 1'b1;
        first_addr = 3'd5;
        last_addr  = 3'd5;
        @(negedge clk);
        start = 1'b0;
        expect_beat("t5_b1", 1, 200, 0, 0);
        expect_beat("t5_b2", 2, 99, 0, 0);
        expect_beat("t5_b3", 3, 1023, 1, 0);
        expect_done("t5", 9);
        repeat (3) @(negedge clk);
        check("t5_idle_busy",  32'(busy),      32'd0);
        check("t5_idle_valid", 32'(out_valid), 32'd0);

        // 6. Reset in the middle of a dump, then a fresh dump
        pulses0 = done_pulses;
        do_start(3'd0, 3'd3);
        expect_beat("t6_b0", 0, 55, 0, 0);
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy",  32'(busy),      32'd0);
        check("t6_rst_done",  32'(done),      32'd0);
        check("t6_rst_data",  32'(out_data),  32'd0);
        check("t6_rst_raddr", 32'(raddr),     32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_no_pulse", 32'(done_pulses - pulses0), 32'd0);
        do_start(3'd1, 3'd2);
        expect_beat("t6_n0", 1, 200, 0, 0);
        expect_beat("t6_n1", 2, 99, 1, 0);
        expect_done("t6", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_dump_reader
